fetch_prefetch_queue: RTL and testbench

Instruction-fetch front end of the pipelined MIPS core. It sits upstream of the IF/ID pipeline register and replaces the bare PC + PC+4 adder path.
- Owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake.
- Buffers returned instructions with their PC+4 in a small in-order queue.
- Presents the queue head to IF/ID with a valid/ready handshake.
- Flushes the queue and discards in-flight responses when the later stages redirect the PC (branch, j/jal, jr).

---
 rtl/fetch_prefetch_queue_pkg.sv | 18 +
 rtl/instr_fifo.sv | 50 +++++
 rtl/fetch_prefetch_queue.sv | 95 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants and queue entry type for the instruction-fetch front end.
package fetch_prefetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

    // Fetches are word-granular; the byte offset of a jump target is dropped.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry in-order queue of fetched instructions with flush and occupancy count.
module instr_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop; the fetch credit keeps push from overflowing.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues credited word reads and queues
// returned instructions for IF/ID, discarding stale words after a redirect.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_plus_4_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop;
    logic [SUM_W-1:0] credit_used;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      target_pc;
    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
    assign credit_used = SUM_W'(occupancy) + SUM_W'(outstanding);
    assign imem_req_o  = reset && !redirect_i && (credit_used < SUM_W'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp             = imem_rvalid_i && (outstanding != '0);
    assign outstanding_next = outstanding + CNT_W'(issue) - CNT_W'(resp);
    assign push             = resp && (drop == '0) && !redirect_i;
    assign push_entry       = '{instr: imem_rdata_i, pc_plus_4: resp_pc + PC_STEP};
    assign target_pc        = word_align(redirect_pc_i);

    assign id_valid_o     = occupancy != '0;
    assign pop            = id_valid_o && id_ready_i && !redirect_i;
    assign id_instr_o     = id_valid_o ? head.instr : NOP_INSTR;
    assign id_pc_plus_4_o = id_valid_o ? head.pc_plus_4 : 32'h0;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_i),
        .count     (occupancy),
        .head      (head)
    );

    // On redirect every word still in flight after this cycle becomes stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                drop     <= outstanding_next;
            end else begin
                if (issue)               fetch_pc <= fetch_pc + PC_STEP;
                if (push)                resp_pc  <= resp_pc + PC_STEP;
                if (resp && drop != '0)  drop     <= drop - CNT_W'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(imem_rvalid_i && outstanding == '0))
        else $error("imem_rvalid_i with no outstanding fetch");

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized scoreboard bench for fetch_prefetch_queue with an epoch-based fetch model.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_plus_4_o;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .id_valid_o     (id_valid_o),
        .id_ready_i     (id_ready_i),
        .id_instr_o     (id_instr_o),
        .id_pc_plus_4_o (id_pc_plus_4_o)
    );

    // Memory returns the word address as the instruction word.
    typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned due; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } item_t;

    req_t        pend[$];
    item_t       expq[$];
    logic [31:0] next_fetch = RESET_PC;
    int unsigned epoch = 0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_pop = 0;

    int unsigned p_gnt = 100, p_ready = 100, p_rvalid = 100, p_redir = 0;
    int unsigned lat_min = 1, lat_max = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;

    bit          c_redir, c_req, c_gnt, c_rvalid;
    logic [31:0] c_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int unsigned p);
        return $urandom_range(99) < p;
    endfunction

    // Apply the effects of the cycle that just ended to the reference model.
    task automatic commit();
        req_t r;
        if (c_rvalid) begin
            r = pend.pop_front();
            if (!c_redir && r.epoch == epoch) expq.push_back('{r.addr, r.addr + 32'd4});
        end
        if (c_redir) begin
            expq.delete();
            epoch++;
            next_fetch = c_rpc & ~32'h3;
        end else if (c_req && c_gnt) begin
            pend.push_back('{next_fetch, epoch, cyc + $urandom_range(lat_max, lat_min)});
            next_fetch = next_fetch + 32'd4;
        end
    endtask

    task automatic drive();
        if (!reset) begin
            redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; id_ready_i = 0;
            c_redir = 0; c_gnt = 0; c_rvalid = 0; c_rpc = 0;
            return;
        end
        redirect_i    = force_redir || roll(p_redir);
        redirect_pc_i = force_redir ? force_pc : $urandom;
        imem_gnt_i    = roll(p_gnt);
        id_ready_i    = force_redir || roll(p_ready);
        imem_rvalid_i = 0;
        imem_rdata_i  = $urandom;
        if (pend.size() != 0 && pend[0].due <= cyc && (force_redir || roll(p_rvalid))) begin
            imem_rvalid_i = 1;
            imem_rdata_i  = pend[0].addr;
        end
        force_redir = 0;
        c_redir = redirect_i; c_rpc = redirect_pc_i; c_gnt = imem_gnt_i; c_rvalid = imem_rvalid_i;
    endtask

    task automatic do_cycle(input bit release_rst);
        @(posedge clk);
        if (reset) commit();
        cyc++;
        #1;
        if (release_rst) reset = 1'b1;
        drive();
        #1;
        c_req = imem_req_o;
    endtask

    task automatic assert_reset_check();
        reset = 1'b0;
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", id_valid_o, 0);
        chk("rst_instr", id_instr_o, 0);
        chk("rst_pc4", id_pc_plus_4_o, 0);
        pend.delete();
        expq.delete();
        next_fetch = RESET_PC;
        epoch++;
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle and retires popped entries.
    initial begin
        bit er;
        forever begin
            @(negedge clk);
            if (reset) begin
                er = !redirect_i && (expq.size() + pend.size() < DEPTH);
                chk("imem_req", imem_req_o, er);
                if (er && imem_req_o) chk("imem_addr", imem_addr_o, next_fetch);
                chk("id_valid", id_valid_o, expq.size() != 0);
                if (expq.size() != 0) begin
                    chk("id_instr", id_instr_o, expq[0].instr);
                    chk("id_pc4", id_pc_plus_4_o, expq[0].pc4);
                    if (id_ready_i && !redirect_i) void'(expq.pop_front());
                end else begin
                    chk("idle_instr", id_instr_o, 0);
                    chk("idle_pc4", id_pc_plus_4_o, 0);
                end
                if (id_valid_o && id_ready_i && !redirect_i) n_pop++;
            end
        end
    end

    initial begin
        int k;
        #1 assert_reset_check();
        repeat (3) do_cycle(0);

        // Streaming: gnt every cycle, 1-cycle memory, IF/ID always ready.
        n_pop = 0;
        do_cycle(1);
        repeat (29) do_cycle(0);
        @(negedge clk); #1;
        chk("stream_pops", n_pop, 28);

        // Stall until the credit limit holds the request low, then drain.
        p_ready = 0;
        repeat (20) do_cycle(0);
        chk("stall_req_low", imem_req_o, 0);
        p_ready = 100;
        repeat (10) do_cycle(0);

        // Redirect with slow memory and words in flight.
        lat_min = 3; lat_max = 3;
        k = 0;
        while (pend.size() < 2 && k < 20) begin do_cycle(0); k++; end
        chk("inflight_reached", pend.size() >= 2, 1);
        force_redir = 1; force_pc = 32'h0040_0100;
        do_cycle(0);
        k = 0;
        do begin do_cycle(0); k++; end while (!id_valid_o && k < 30);
        chk("redir_timeout", k < 30, 1);
        chk("redir_instr", id_instr_o, 32'h0040_0100);
        chk("redir_pc4", id_pc_plus_4_o, 32'h0040_0104);

        // Redirect coincident with a response and a pop.
        lat_min = 1; lat_max = 1;
        repeat (8) do_cycle(0);
        force_redir = 1; force_pc = 32'h0040_0200;
        do_cycle(0);
        do_cycle(0);
        chk("flush_empty", id_valid_o, 0);

        // Misaligned redirect target.
        repeat (4) do_cycle(0);
        force_redir = 1; force_pc = 32'h0040_0103;
        do_cycle(0);
        do_cycle(0);
        chk("aligned_fetch", imem_addr_o, 32'h0040_0100);

        // Random traffic, then a burst of frequent (back-to-back) redirects.
        p_gnt = 70; p_ready = 60; p_rvalid = 75; p_redir = 4; lat_min = 1; lat_max = 4;
        repeat (800) do_cycle(0);
        p_redir = 30;
        repeat (150) do_cycle(0);

        // Reset mid-stream with a full queue and words in flight.
        p_redir = 0; p_gnt = 100; p_ready = 0; p_rvalid = 100; lat_min = 3; lat_max = 3;
        repeat (6) do_cycle(0);
        #1 assert_reset_check();
        repeat (3) do_cycle(0);
        p_ready = 100; lat_min = 1; lat_max = 1;
        do_cycle(1);
        chk("post_rst_addr", imem_addr_o, RESET_PC);
        repeat (30) do_cycle(0);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
